clint_timer: RTL
================

Name: clint_timer

Overview:
- Core-local interruptor; the source side of the core's `mip` interrupt-pending input.
- Holds a 64-bit free-running `mtime` counter with a programmable prescaler, a 64-bit `mtimecmp` compare register and a software-interrupt register `msip`.
- Drives `mip_out` with MTIP at bit 7 and MSIP at bit 3.
- Software reaches these registers over a simple single-beat memory-mapped request/acknowledge bus.

Parameters:
- `PRESC_W`, 16: width of the prescaler divisor register and its internal counter.
- `MTIMECMP_RST`, 64'hFFFF_FFFF_FFFF_FFFF: reset value of `mtimecmp`, chosen so MTIP is never asserted out of reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `bus_req` input 1: access request, held until `bus_ack`.
- `bus_we` input 1: 1 = write, 0 = read; valid with `bus_req`.
- `bus_addr` input 5: byte offset; bits [1:0] ignored.
- `bus_wdata` input 32: write data.
- `bus_rdata` output 32: read data, valid while `bus_ack` = 1.
- `bus_ack` output 1: one-cycle access-complete pulse.
- `mip_out` output 32: bit 7 = MTIP, bit 3 = MSIP, all other bits 0.
- `mtime_tick` output 1: high for one cycle on each `mtime` increment.

Behaviour:
- Register map:
  - 0x00 `msip`: only bit 0 is stored; reads return {31'b0, msip}.
  - 0x04 `mtimecmp`[31:0].
  - 0x08 `mtimecmp`[63:32].
  - 0x0C `mtime`[31:0].
  - 0x10 `mtime`[63:32].
  - 0x14 `presc_div`: only [PRESC_W-1:0] is stored; reads zero-extend.
  - Any other offset: read returns 0, write is ignored, `bus_ack` is still given.
- Reset, applied at a `clk` edge with `reset_n` = 0:
  - `mtime` = 0, `presc_cnt` = 0, `presc_div` = 0, `msip` = 0.
  - `mtimecmp` = `MTIMECMP_RST`.
  - `bus_ack` = 0, `bus_rdata` = 0, `mip_out` = 0, `mtime_tick` = 0.
  - Reset during an in-flight access aborts it: no ack, no write.
- Bus handshake, two states:
  - IDLE: an access is accepted when `bus_req` = 1. On that edge the write is performed, or `bus_rdata` is registered. Go to ACK.
  - ACK: `bus_ack` = 1 for exactly one cycle; `bus_req` is ignored. Return to IDLE.
  - Consequence: a `bus_req` held continuously is serviced once every 2 cycles. Fixed latency: request at cycle N, `bus_ack` at cycle N+1.
  - `bus_rdata` holds its last value when `bus_ack` = 0.
- Prescaler:
  - When `presc_cnt` == `presc_div`: `presc_cnt` <= 0, `mtime` <= `mtime` + 1 (64-bit, wraps from all-ones to 0), and `mtime_tick` = 1 in the following cycle.
  - Otherwise `presc_cnt` increments.
  - `presc_div` = 0 gives one increment per cycle; `presc_div` = D gives one increment every D+1 cycles.
  - Writing `presc_div` also clears `presc_cnt` on the same edge.
- `mtime` write vs increment in the same cycle:
  - The write wins. The written half takes `bus_wdata`; the other half keeps its pre-increment value.
  - No increment is lost into the unwritten half; that tick is dropped.
  - `presc_cnt` still advances or clears as normal.
- Lo-word carry: when an increment carries out of [31:0], [63:32] increments on the same edge.
- Reading `mtime`: lo and hi reads are independent. Software is responsible for the hi-lo-hi read sequence; no shadow latch.
- MTIP:
  - Registered: `mip_out`[7] <= (`mtime` >= `mtimecmp`), an unsigned 64-bit compare on the current register values.
  - One-cycle lag after `mtime` or `mtimecmp` changes.
  - Level-sensitive: it clears only when `mtimecmp` is raised above `mtime` or `mtime` is rewritten below it.
- MSIP: `mip_out`[3] <= `msip`, with one-cycle lag after the write edge.
- Writes to a `mtimecmp` half take effect on the accept edge. Software writes hi = all-ones first to avoid a spurious MTIP.

Test Plan:
- Reset, then read 0x08 → `bus_ack` exactly 1 cycle after `bus_req`, `bus_rdata` = 32'hFFFF_FFFF; `mip_out` = 0 for ≥100 cycles.
- `presc_div` = 3, `mtime` = 0, run 40 cycles → `mtime` = 10 (±1 depending on phase), `mtime_tick` pulses spaced exactly 4 cycles.
- `presc_div` = 0:
  - `mtimecmp` = {hi 0, lo 20}, `mtime` = 0 → `mip_out`[7] rises the cycle after `mtime` reaches 20.
  - Then write `mtimecmp` lo = 1000 → `mip_out`[7] falls 1 cycle after the write ack edge.
- `mtime` lo = 32'hFFFF_FFFE, hi = 0, `presc_div` = 0 → after 2 ticks lo = 0, hi = 1.
- Write `mtime` lo = 5 on a cycle where a tick is due → lo = 5 and hi unchanged, then normal counting resumes.
- Write 0x00 = 32'hFFFF_FFFF → `mip_out` = 32'h0000_0008, read 0x00 = 1.
- Hold `bus_req` high for 6 cycles → 3 acks.
- Unmapped 0x18 write then read → ack given, data 0, other registers unchanged.

Source files
------------

// File: rtl/clint_timer.sv
// Core-local interruptor: 64-bit mtime with prescaler, mtimecmp compare,
// msip software interrupt, and a two-state request/acknowledge register bus.
module clint_timer #(
    parameter int          PRESC_W      = 16,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bus_req,
    input  logic        bus_we,
    input  logic [4:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic [31:0] mip_out,
    output logic        mtime_tick
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t               state_q;
    logic                 ack_q;
    logic [31:0]          rdata_q;

    logic [63:0]          mtime_q, mtime_d;
    logic [63:0]          mtimecmp_q, mtimecmp_d;
    logic [PRESC_W-1:0]   presc_cnt_q, presc_cnt_d;
    logic [PRESC_W-1:0]   presc_div_q, presc_div_d;
    logic                 msip_q, msip_d;
    logic                 mtip_q, msip_out_q, tick_q;

    logic                 accept_s;
    logic                 wr_s;
    logic                 tick_s;
    logic                 mtime_wr_s;
    logic [2:0]           word_s;
    logic [31:0]          rd_mux_s;
    logic                 unused_s;

    assign accept_s = (state_q == ST_IDLE) && bus_req;
    assign wr_s     = accept_s && bus_we;
    assign word_s   = bus_addr[4:2];
    assign tick_s   = (presc_cnt_q == presc_div_q);
    assign unused_s = &{1'b0, bus_addr[1:0]};

    // Next-state for timer registers: prescaled increment, then bus writes override.
    always_comb begin
        msip_d      = msip_q;
        mtimecmp_d  = mtimecmp_q;
        presc_div_d = presc_div_q;
        mtime_wr_s  = 1'b0;
        if (tick_s) begin
            mtime_d     = mtime_q + 64'd1;
            presc_cnt_d = '0;
        end else begin
            mtime_d     = mtime_q;
            presc_cnt_d = presc_cnt_q + PRESC_W'(1);
        end
        if (wr_s) begin
            case (word_s)
                3'd0: msip_d = bus_wdata[0];
                3'd1: mtimecmp_d = {mtimecmp_q[63:32], bus_wdata};
                3'd2: mtimecmp_d = {bus_wdata, mtimecmp_q[31:0]};
                // A write to one mtime half wins over a same-cycle tick; the
                // other half keeps its pre-increment value, so the tick is dropped.
                3'd3: begin
                    mtime_d    = {mtime_q[63:32], bus_wdata};
                    mtime_wr_s = 1'b1;
                end
                3'd4: begin
                    mtime_d    = {bus_wdata, mtime_q[31:0]};
                    mtime_wr_s = 1'b1;
                end
                3'd5: begin
                    presc_div_d = bus_wdata[PRESC_W-1:0];
                    presc_cnt_d = '0;
                end
                default: ;
            endcase
        end else begin
            msip_d = msip_q;
        end
    end

    // Read-data mux over current register values; unmapped offsets read zero.
    always_comb begin
        rd_mux_s = 32'd0;
        case (word_s)
            3'd0:    rd_mux_s = {31'd0, msip_q};
            3'd1:    rd_mux_s = mtimecmp_q[31:0];
            3'd2:    rd_mux_s = mtimecmp_q[63:32];
            3'd3:    rd_mux_s = mtime_q[31:0];
            3'd4:    rd_mux_s = mtime_q[63:32];
            3'd5:    rd_mux_s = {{(32 - PRESC_W){1'b0}}, presc_div_q};
            default: rd_mux_s = 32'd0;
        endcase
    end

    // Bus handshake FSM with registered ack and read data.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus_req) begin
                        state_q <= ST_ACK;
                        ack_q   <= 1'b1;
                        if (!bus_we) begin
                            rdata_q <= rd_mux_s;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // Timer state and registered interrupt/tick outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mtime_q     <= 64'd0;
            mtimecmp_q  <= MTIMECMP_RST;
            presc_cnt_q <= '0;
            presc_div_q <= '0;
            msip_q      <= 1'b0;
            mtip_q      <= 1'b0;
            msip_out_q  <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            presc_cnt_q <= presc_cnt_d;
            presc_div_q <= presc_div_d;
            msip_q      <= msip_d;
            mtip_q      <= (mtime_q >= mtimecmp_q);
            msip_out_q  <= msip_q;
            tick_q      <= tick_s && !mtime_wr_s;
        end
    end

    assign bus_ack    = ack_q;
    assign bus_rdata  = rdata_q;
    assign mtime_tick = tick_q;
    assign mip_out    = {24'd0, mtip_q, 3'd0, msip_out_q, 3'd0};

endmodule
